vga_field_scanner: RTL

- Sequencer for the BCD field-select multiplexer that feeds the VGA text renderer.
- On each vertical sync it steps the 4-bit field select through every time/date/timer field, waits for the mux to settle, and captures the decenas/unidades nibbles into a shadow bank.
- At the end of the scan it commits the whole bank atomically to a snapshot register, so the renderer always reads one coherent frame.
- Also reports overruns and, optionally, generates a frame-locked blink flag.

---
 rtl/vga_field_scanner.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vga_field_scanner.sv
// vga_field_scanner
//   On every vsync falling edge, walks the BCD field-select mux through all
//   fields. Each select is held for SETTLE cycles before capture. The captured
//   {dec,uni} nibbles go into a shadow bank. The complete bank is then
//   committed to snap in a single edge, so the renderer never sees a torn frame.
//
// Ports
//   clk, reset    clock and asynchronous active-high reset
//   vsync         active-low vertical sync (asynchronous, synchronised here)
//   freeze        inhibits starting new scans (sampled only while idle)
//   dec, uni      BCD digits returned by the mux for the current sel
//   sel           field select to the mux
//   snap          committed snapshot, field k at [8k+7:8k] = {dec,uni}
//   busy          scan in progress
//   frame_done    one-cycle pulse in the cycle that commits snap
//   overrun       sticky: a trigger arrived while busy
//   blink         frame-locked blink flag
//
// Optional feature: define VGA_SCAN_BLINK_EN to enable the blink counter.
// When it is undefined, blink is tied low.

module vga_field_scanner #(
   parameter int unsigned NUM_FIELDS   = 9,
   parameter int unsigned SETTLE       = 2,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    vsync,
   input  logic                    freeze,
   input  logic [3:0]              dec,
   input  logic [3:0]              uni,
   output logic [3:0]              sel,
   output logic [8*NUM_FIELDS-1:0] snap,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    overrun,
   output logic                    blink
);

   localparam int unsigned CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] CntLast = CW'(SETTLE - 1);
   localparam logic [3:0]    IdxLast = 4'(NUM_FIELDS - 1);

   if (NUM_FIELDS < 1 || NUM_FIELDS > 16 || SETTLE < 1 || BLINK_FRAMES < 1) begin : gen_param_err
      $error("vga_field_scanner: illegal parameter value");
   end

   typedef enum logic [1:0] {StIdle, StSetup, StCapture, StDone} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              idx_q, idx_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [8*NUM_FIELDS-1:0] shadow_q, shadow_d;
   logic [8*NUM_FIELDS-1:0] snap_q, snap_d;
   logic                    overrun_q, overrun_d;
   logic                    vs_s1_q, vs_s2_q, vs_s3_q;
   logic                    trig_q, trig_d;
   logic [3:0]              dec_c, uni_c;

   // Two-flop synchroniser, then a registered falling-edge detect.
   assign trig_d = vs_s3_q & ~vs_s2_q;

   // Out-of-range nibbles are flagged as F so the renderer can show a blank.
   assign dec_c = (dec > 4'd9) ? 4'hF : dec;
   assign uni_c = (uni > 4'd9) ? 4'hF : uni;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      snap_d     = snap_q;
      overrun_d  = overrun_q;
      sel        = 4'd0;
      busy       = (state_q != StIdle);
      frame_done = (state_q == StDone);

      if (trig_q && busy) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (trig_q && !freeze) begin
               idx_d   = 4'd0;
               cnt_d   = '0;
               state_d = StSetup;
            end
         end
         StSetup: begin
            sel   = idx_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            sel = idx_q;
            for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
               if (idx_q == 4'(k)) begin
                  shadow_d[8*k +: 8] = {dec_c, uni_c};
               end
            end
            if (idx_q == IdxLast) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 4'd1;
               cnt_d   = '0;
               state_d = StSetup;
            end
         end
         StDone: begin
            snap_d  = shadow_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         idx_q     <= 4'd0;
         cnt_q     <= '0;
         shadow_q  <= '0;
         snap_q    <= '0;
         overrun_q <= 1'b0;
         vs_s1_q   <= 1'b1;
         vs_s2_q   <= 1'b1;
         vs_s3_q   <= 1'b1;
         trig_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         snap_q    <= snap_d;
         overrun_q <= overrun_d;
         vs_s1_q   <= vsync;
         vs_s2_q   <= vs_s1_q;
         vs_s3_q   <= vs_s2_q;
         trig_q    <= trig_d;
      end
   end

   assign snap    = snap_q;
   assign overrun = overrun_q;

`ifdef VGA_SCAN_BLINK_EN
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FcntLast = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          blink_q, blink_d;

   // Only committed frames advance the counter; frozen triggers never reach StDone.
   always_comb begin
      fcnt_d  = fcnt_q;
      blink_d = blink_q;
      if (state_q == StDone) begin
         if (fcnt_q == FcntLast) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fcnt_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_d;
         blink_q <= blink_d;
      end
   end

   assign blink = blink_q;
`else
   assign blink = 1'b0;
`endif

endmodule
